// File: rtl/spi_slave_deser.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_deser
// Purpose  : Mode-0, MSB-first SPI slave shifter. It oversamples the SPI pins
//            in the refclk domain. Completed receive words are pushed to an
//            RX FIFO and transmit words are popped from a show-ahead TX FIFO.
//            Overruns, underruns and truncated frames are kept as sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_deser #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             slave_sclk,
    input  logic             slave_csn,
    input  logic             slave_mosi,
    output logic             slave_miso,
    output logic             slave_miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             clr_errors,
    output logic             rx_overflow,
    output logic             tx_underflow,
    output logic             frame_error,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // Input synchronizers, history flops and registered edge pulses.
    // The csn chain resets low so that a csn already low at reset release
    // never looks like a falling edge; a genuine high phase is required first.
    logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, mosi_sync_q;
    logic                   sclk_hist_q, csn_hist_q, mosi_hist_q;
    logic                   sclk_rise_q, sclk_fall_q, csn_fall_q, csn_rise_q;

    // FSM and datapath state.
    state_t           state_q, state_d;
    logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
    // Holds the WIDTH-1 bits received so far; the last bit is appended
    // directly when the word is handed to the RX FIFO.
    logic [WIDTH-2:0] rx_sr_q, rx_sr_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic             skip_fall_q, skip_fall_d;
    logic             rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             ovf_q, udf_q, ferr_q;
    logic             set_udf, set_ferr;
    logic [WIDTH-1:0] word_w;

    // Synchronize the SPI pins and turn level changes into one-cycle pulses.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            csn_sync_q  <= '0;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            csn_hist_q  <= 1'b0;
            mosi_hist_q <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            csn_fall_q  <= 1'b0;
            csn_rise_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], slave_sclk};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], slave_csn};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], slave_mosi};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            csn_hist_q  <= csn_sync_q[SYNC_STAGES-1];
            mosi_hist_q <= mosi_sync_q[SYNC_STAGES-1];
            sclk_rise_q <=  sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q;
            sclk_fall_q <= ~sclk_sync_q[SYNC_STAGES-1] &  sclk_hist_q;
            csn_fall_q  <= ~csn_sync_q[SYNC_STAGES-1]  &  csn_hist_q;
            csn_rise_q  <=  csn_sync_q[SYNC_STAGES-1]  & ~csn_hist_q;
        end
    end

    // State, shift registers, RX output register and sticky flags.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            bitcnt_q    <= '0;
            skip_fall_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            bitcnt_q    <= bitcnt_d;
            skip_fall_q <= skip_fall_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            // Set beats clear when both happen in the same cycle.
            ovf_q       <= (ovf_q  & ~clr_errors) | (rx_valid_q & ~rx_ready);
            udf_q       <= (udf_q  & ~clr_errors) | set_udf;
            ferr_q      <= (ferr_q & ~clr_errors) | set_ferr;
        end
    end

    // Next-state and datapath logic for the IDLE / LOAD / SHIFT sequence.
    always_comb begin
        state_d     = state_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        bitcnt_d    = bitcnt_q;
        skip_fall_d = skip_fall_q;
        rx_valid_d  = 1'b0;
        rx_data_d   = rx_data_q;
        set_udf     = 1'b0;
        set_ferr    = 1'b0;
        word_w      = {rx_sr_q, mosi_hist_q};

        case (state_q)
            ST_IDLE: begin
                bitcnt_d = '0;
                if (csn_fall_q) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                tx_sr_d     = tx_valid ? tx_data : '0;
                set_udf     = ~tx_valid;
                bitcnt_d    = '0;
                skip_fall_d = 1'b1;
                state_d     = csn_rise_q ? ST_IDLE : ST_SHIFT;
            end

            ST_SHIFT: begin
                if (sclk_rise_q) begin
                    rx_sr_d = word_w[WIDTH-2:0];
                    // Only a falling edge that precedes the first rise after a
                    // load is the tail of the previous word's last bit; once a
                    // rise has been seen every fall advances the TX shifter.
                    skip_fall_d = 1'b0;
                    if (bitcnt_q == CW'(WIDTH - 1)) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = word_w;
                        bitcnt_d   = '0;
                        state_d    = ST_LOAD;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
                if (sclk_fall_q) begin
                    if (skip_fall_q) begin
                        skip_fall_d = 1'b0;
                    end else begin
                        tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
                    end
                end
                // A word completing in the same cycle leaves bitcnt_d at zero,
                // so it is delivered and no frame error is raised.
                if (csn_rise_q) begin
                    set_ferr = (bitcnt_d != '0);
                    bitcnt_d = '0;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign slave_miso    = (state_q != ST_IDLE) ? tx_sr_q[WIDTH-1] : 1'b0;
    assign slave_miso_oe = (state_q != ST_IDLE) & ~csn_hist_q;
    assign tx_ready      = (state_q == ST_LOAD);
    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_overflow   = ovf_q;
    assign tx_underflow  = udf_q;
    assign frame_error   = ferr_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_deser
// Purpose  : Self-checking bench for spi_slave_deser. A mode-0 SPI master and
//            a show-ahead TX FIFO model drive the block; expected words and
//            flags come from a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_deser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        csn = 1'b0;
    logic        mosi = 1'b0;
    logic        rx_ready = 1'b1;
    logic        clr_errors = 1'b0;
    logic [15:0] tx_data = 16'h0;
    logic        tx_valid = 1'b0;
    logic        slave_miso, slave_miso_oe, rx_valid, tx_ready;
    logic        rx_overflow, tx_underflow, frame_error, busy;
    logic [15:0] rx_data;

    int          checks = 0;
    int          errors = 0;
    int          rxv_cnt = 0;
    int          txr_cnt = 0;
    logic [15:0] rx_log[$];
    logic        rdy_log[$];
    logic [15:0] tx_mem[256];
    int          tx_rd = 0;
    int          tx_wr = 0;
    logic [15:0] m_out[8];
    logic [15:0] m_in[8];
    logic        busy_after;
    logic        oe_mid;

    spi_slave_deser #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .refclk        (clk),
        .rst           (rst),
        .slave_sclk    (sclk),
        .slave_csn     (csn),
        .slave_mosi    (mosi),
        .slave_miso    (slave_miso),
        .slave_miso_oe (slave_miso_oe),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .clr_errors    (clr_errors),
        .rx_overflow   (rx_overflow),
        .tx_underflow  (tx_underflow),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Show-ahead TX FIFO model plus observation of both FIFO handshakes.
    always @(negedge clk) begin
        tx_valid = (tx_rd < tx_wr);
        tx_data  = (tx_rd < tx_wr) ? tx_mem[tx_rd] : 16'h0;
        if (tx_ready) begin
            txr_cnt++;
            if (tx_rd < tx_wr) tx_rd++;
        end
        if (rx_valid) begin
            rxv_cnt++;
            rx_log.push_back(rx_data);
            rdy_log.push_back(rx_ready);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic push_tx(input logic [15:0] w);
        tx_mem[tx_wr] = w;
        tx_wr++;
    endtask

    task automatic clear_flags();
        clr_errors = 1'b1;
        @(negedge clk);
        clr_errors = 1'b0;
        @(negedge clk);
    endtask

    // Mode-0 master: clocks nbits bits from m_out, captures MISO into m_in.
    task automatic spi_frame(input int nbits, input int hp);
        csn = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            mosi = m_out[b / 16][15 - (b % 16)];
            repeat (hp) @(negedge clk);
            m_in[b / 16][15 - (b % 16)] = slave_miso;
            if (b == 0) oe_mid = slave_miso_oe;
            sclk = 1'b1;
            repeat (hp) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (hp) @(negedge clk);
        csn  = 1'b1;
        mosi = 1'b0;
        repeat (5) @(negedge clk);
        busy_after = busy;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        csn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({slave_miso, slave_miso_oe, rx_valid, tx_ready, rx_overflow,
             tx_underflow, frame_error, busy, rx_data} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b tx_ready=%b rx_data=%h, required all zero",
                     busy, tx_ready, rx_data);
        end
        // csn already low at reset release must not start a frame.
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || txr_cnt !== 0) begin
            errors++;
            $display("FAIL csn_low_at_reset: got busy=%b pops=%0d, required busy=0 pops=0",
                     busy, txr_cnt);
        end
        csn = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single_word();
        int rxi, rxv0, txr0;
        push_tx(16'hA503);
        push_tx(16'h1234);
        m_out[0] = 16'h3C5A;
        rxi = rx_log.size(); rxv0 = rxv_cnt; txr0 = txr_cnt;
        spi_frame(16, 6);
        checks++;
        if (m_in[0] !== 16'hA503) begin
            errors++;
            $display("FAIL single_miso: got %h, required a503", m_in[0]);
        end
        checks++;
        if (rxv_cnt - rxv0 !== 1) begin
            errors++;
            $display("FAIL single_rx_count: got %0d, required 1", rxv_cnt - rxv0);
        end else begin
            checks++;
            if (rx_log[rxi] !== 16'h3C5A) begin
                errors++;
                $display("FAIL single_rx_data: got %h, required 3c5a", rx_log[rxi]);
            end
        end
        checks++;
        if (txr_cnt - txr0 !== 2) begin
            errors++;
            $display("FAIL single_pops: got %0d, required 2", txr_cnt - txr0);
        end
        checks++;
        if (oe_mid !== 1'b1 || busy_after !== 1'b0) begin
            errors++;
            $display("FAIL single_oe_busy: got oe=%b busy_after=%b, required oe=1 busy_after=0",
                     oe_mid, busy_after);
        end
        checks++;
        if ({rx_overflow, tx_underflow, frame_error} !== 3'b000) begin
            errors++;
            $display("FAIL single_flags: got %b, required 000",
                     {rx_overflow, tx_underflow, frame_error});
        end
    endtask

    task automatic test_back_to_back();
        int rxi, rxv0, txr0;
        for (int i = 0; i < 4; i++) push_tx(16'(i + 1));
        push_tx(16'hBEEF);
        for (int i = 0; i < 4; i++) m_out[i] = 16'($urandom);
        rxi = rx_log.size(); rxv0 = rxv_cnt; txr0 = txr_cnt;
        spi_frame(64, 6);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_in[i] !== 16'(i + 1)) begin
                errors++;
                $display("FAIL b2b_miso[%0d]: got %h, required %h", i, m_in[i], 16'(i + 1));
            end
        end
        checks++;
        if (rxv_cnt - rxv0 !== 4) begin
            errors++;
            $display("FAIL b2b_rx_count: got %0d, required 4", rxv_cnt - rxv0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx_log[rxi + i] !== m_out[i]) begin
                    errors++;
                    $display("FAIL b2b_rx_data[%0d]: got %h, required %h",
                             i, rx_log[rxi + i], m_out[i]);
                end
            end
        end
        checks++;
        if ({rx_overflow, tx_underflow, frame_error} !== 3'b000 || txr_cnt - txr0 !== 5) begin
            errors++;
            $display("FAIL b2b_flags_pops: got flags=%b pops=%0d, required flags=000 pops=5",
                     {rx_overflow, tx_underflow, frame_error}, txr_cnt - txr0);
        end
    endtask

    task automatic test_underflow();
        int rxi, rxv0;
        m_out[0] = 16'($urandom);
        rxi = rx_log.size(); rxv0 = rxv_cnt;
        spi_frame(16, 6);
        checks++;
        if (m_in[0] !== 16'h0000 || tx_underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow: got miso_word=%h flag=%b, required 0000 and 1",
                     m_in[0], tx_underflow);
        end
        checks++;
        if (rxv_cnt - rxv0 !== 1 || rx_log[rxi] !== m_out[0]) begin
            errors++;
            $display("FAIL underflow_rx: got count=%0d, required 1 word %h",
                     rxv_cnt - rxv0, m_out[0]);
        end
        clear_flags();
        checks++;
        if (tx_underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: got %b, required 0", tx_underflow);
        end
    endtask

    task automatic test_overflow();
        int rxi, rxv0;
        for (int i = 0; i < 3; i++) push_tx(16'($urandom));
        m_out[0] = 16'($urandom);
        m_out[1] = 16'($urandom);
        rxi = rx_log.size(); rxv0 = rxv_cnt;
        fork
            spi_frame(32, 6);
            begin
                int n;
                n = 0;
                while (rxv_cnt == rxv0 && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (rxv_cnt == rxv0) begin
                    errors++;
                    $display("FAIL ovf_wait: got no rx_valid in 1000 cycles, required one");
                end
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        rx_ready = 1'b1;
        checks++;
        if (rxv_cnt - rxv0 !== 2) begin
            errors++;
            $display("FAIL ovf_count: got %0d, required 2", rxv_cnt - rxv0);
        end else begin
            checks++;
            if (rdy_log[rxi] !== 1'b1 || rdy_log[rxi + 1] !== 1'b0 || rx_log[rxi] !== m_out[0]) begin
                errors++;
                $display("FAIL ovf_handshake: got ready=%b,%b data0=%h, required 1,0 and %h",
                         rdy_log[rxi], rdy_log[rxi + 1], rx_log[rxi], m_out[0]);
            end
        end
        checks++;
        if ({rx_overflow, tx_underflow, frame_error} !== 3'b100) begin
            errors++;
            $display("FAIL ovf_flags: got %b, required 100",
                     {rx_overflow, tx_underflow, frame_error});
        end
        clear_flags();
    endtask

    task automatic test_partial_frame();
        int rxi, rxv0, txr0;
        push_tx(16'($urandom));
        m_out[0] = 16'($urandom);
        rxv0 = rxv_cnt; txr0 = txr_cnt;
        spi_frame(7, 6);
        checks++;
        if (rxv_cnt !== rxv0 || frame_error !== 1'b1 || busy_after !== 1'b0) begin
            errors++;
            $display("FAIL partial: got rx=%0d ferr=%b busy=%b, required rx=0 ferr=1 busy=0",
                     rxv_cnt - rxv0, frame_error, busy_after);
        end
        checks++;
        if (txr_cnt - txr0 !== 1) begin
            errors++;
            $display("FAIL partial_pops: got %0d, required 1", txr_cnt - txr0);
        end
        clear_flags();
        push_tx(16'h5AA5);
        push_tx(16'($urandom));
        m_out[0] = 16'($urandom);
        rxi = rx_log.size(); rxv0 = rxv_cnt;
        spi_frame(16, 7);
        checks++;
        if (rxv_cnt - rxv0 !== 1 || rx_log[rxi] !== m_out[0] || m_in[0] !== 16'h5AA5
            || frame_error !== 1'b0) begin
            errors++;
            $display("FAIL after_partial: got count=%0d miso=%h ferr=%b, required 1 %h 5aa5 0",
                     rxv_cnt - rxv0, m_in[0], frame_error, m_out[0]);
        end
    endtask

    task automatic test_rst_midframe();
        int rxi, rxv0, txr0;
        push_tx(16'($urandom));
        push_tx(16'hC001);
        push_tx(16'($urandom));
        rxv0 = rxv_cnt; txr0 = txr_cnt;
        csn = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            mosi = 1'($urandom);
            repeat (6) @(negedge clk);
            sclk = 1'b1;
            repeat (6) @(negedge clk);
            sclk = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({slave_miso, slave_miso_oe, rx_valid, tx_ready, rx_overflow,
             tx_underflow, frame_error, busy, rx_data} !== 24'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got busy=%b oe=%b rx_data=%h, required all zero",
                     busy, slave_miso_oe, rx_data);
        end
        rst = 1'b0;
        for (int b = 0; b < 20; b++) begin
            mosi = 1'($urandom);
            repeat (6) @(negedge clk);
            sclk = 1'b1;
            repeat (6) @(negedge clk);
            sclk = 1'b0;
        end
        checks++;
        if (rxv_cnt !== rxv0 || txr_cnt - txr0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ignore: got rx=%0d pops=%0d busy=%b, required 0 1 0",
                     rxv_cnt - rxv0, txr_cnt - txr0, busy);
        end
        csn = 1'b1;
        repeat (10) @(negedge clk);
        m_out[0] = 16'($urandom);
        rxi = rx_log.size();
        spi_frame(16, 6);
        checks++;
        if (rxv_cnt - rxv0 !== 1 || rx_log[rxi] !== m_out[0] || m_in[0] !== 16'hC001
            || txr_cnt - txr0 !== 3) begin
            errors++;
            $display("FAIL rst_mid_recover: got count=%0d miso=%h pops=%0d, required 1 c001 3",
                     rxv_cnt - rxv0, m_in[0], txr_cnt - txr0);
        end
    endtask

    // Random frames: word count, sclk half period and TX FIFO fill level vary.
    task automatic test_random();
        int n, hp, k, rd0, rxi, rxv0, txr0;
        logic [15:0] exp_w;
        for (int f = 0; f < 6; f++) begin
            n  = $urandom_range(1, 3);
            hp = $urandom_range(5, 8);
            k  = $urandom_range(0, n + 1);
            rd0 = tx_wr;
            for (int i = 0; i < k; i++) push_tx(16'($urandom));
            for (int i = 0; i < n; i++) m_out[i] = 16'($urandom);
            rxi = rx_log.size(); rxv0 = rxv_cnt; txr0 = txr_cnt;
            spi_frame(n * 16, hp);
            checks++;
            if (rxv_cnt - rxv0 !== n) begin
                errors++;
                $display("FAIL rand%0d_rx_count: got %0d, required %0d", f, rxv_cnt - rxv0, n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (rx_log[rxi + i] !== m_out[i]) begin
                        errors++;
                        $display("FAIL rand%0d_rx[%0d]: got %h, required %h",
                                 f, i, rx_log[rxi + i], m_out[i]);
                    end
                end
            end
            for (int i = 0; i < n; i++) begin
                exp_w = (i < k) ? tx_mem[rd0 + i] : 16'h0000;
                checks++;
                if (m_in[i] !== exp_w) begin
                    errors++;
                    $display("FAIL rand%0d_miso[%0d]: got %h, required %h", f, i, m_in[i], exp_w);
                end
            end
            checks++;
            if (txr_cnt - txr0 !== n + 1 || tx_underflow !== (k < n + 1)
                || rx_overflow !== 1'b0 || frame_error !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_flags: got pops=%0d udf=%b ovf=%b ferr=%b, required pops=%0d udf=%b 0 0",
                         f, txr_cnt - txr0, tx_underflow, rx_overflow, frame_error,
                         n + 1, (k < n + 1));
            end
            clear_flags();
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_underflow();
        test_overflow();
        test_partial_frame();
        test_rst_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
